serial_adder8: RTL and testbench
================================

Name: serial_adder8

Overview:
- Bit-serial 8-bit adder front end that drives a single full-adder slice one bit per clock, LSB first.
- Accepts operands A, B and carry-in over a valid/ready handshake.
- Shifts the operands through the slice, collects sum bits, and presents SUM/COUT downstream over a second valid/ready handshake.
- Provides an area-minimal alternative to the 8-bit ripple-carry adder, with the same I/O semantics: SUM = A + B + CIN mod 2^WIDTH, COUT = carry out of the MSB.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of MSB
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst high at a rising edge, from any state):
  - state is IDLE and the bit counter is 0.
  - sum = 0, cout = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Any in-flight operation is discarded. No partial result ever appears on sum.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid & in_ready: load shift registers with a and b, load the carry register with cin, clear the bit counter and the sum shift register, then go to SHIFT.
  - Inputs are sampled only on this edge; a, b and cin may change afterwards.
- SHIFT:
  - Each edge: the slice combines a_sh[0], b_sh[0] and the carry register.
  - The slice's sum bit shifts into the sum register MSB (right shift); carry_out loads the carry register; a_sh and b_sh shift right; the counter increments.
  - When the counter reaches WIDTH-1 on an edge, that edge processes the last bit and the next state is DONE.
  - Exactly WIDTH edges are spent in SHIFT.
- DONE:
  - out_valid = 1; sum and cout are stable and held.
  - On the edge where out_valid & out_ready: go to IDLE and drop out_valid.
  - Operands cannot be accepted in DONE; there is no same-cycle turnaround.
- Latency:
  - Accept at edge T; out_valid is high after edge T+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles.
- Backpressure: with out_ready low, DONE holds indefinitely with sum/cout unchanged.
- in_valid while busy: ignored; in_ready is 0, nothing is captured, and no state changes.
- cout is the carry register after the final SHIFT edge.
- Arithmetic is unsigned modulo 2^WIDTH, and must match A+B+CIN bit-exactly for all inputs.
- sum and cout hold their last result in IDLE until the next DONE overwrites them; they are not cleared on accept.

Optional Feature:
- Macro: SERIAL_ADDER8_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0), the two's-complement overflow flag.
  - Captured on the final SHIFT edge as (carry into MSB) XOR (carry out of MSB).
  - Valid and held with out_valid, same as sum.
- Undefined:
  - Port ovf does not exist.
  - There is no MSB carry-in tracking register; logic is otherwise identical.

Decomposition:
- Shared header serial_add_defs.vh contains:
  - FSM state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - The default WIDTH localparam.
- Bench and RTL both include the header.
- One sub-module: the team's existing full-adder cell, instantiated once as the bit slice (inputs a_sh[0], b_sh[0], carry register; outputs sum bit, carry out).
- All control lives in serial_adder8.

Test Plan:
- a=8'hFF, b=8'h01, cin=0 -> after 8 edges out_valid=1, sum=8'h00, cout=1; with the macro, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0; with the macro, ovf=1. a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Backpressure: complete a=8'h35, b=8'h4A, cin=1 with out_ready held low 5 cycles -> sum=8'h80, cout=0 held constant for all 5 cycles; out_valid drops the edge after out_ready rises; in_ready returns high.
- Busy rejection: assert in_valid with a=8'hAA every cycle during SHIFT/DONE -> in_ready=0 throughout; the original result is unaffected; the new operand is accepted only after return to IDLE.
- Reset mid-SHIFT: rst high for 1 cycle at bit 4 -> next cycle state is IDLE, out_valid=0, sum=0, cout=0, in_ready=1; a following 8'h10+8'h20 yields 8'h30.
- Randomized sweep: 500 random {a, b, cin} with random out_ready stalls -> every result equals a+b+cin (9-bit compare); accept-to-valid latency is exactly 8 edges.

Source files
------------

// File: rtl/serial_adder8_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder8_fa.sv
// Single-bit full-adder cell used as the serial adder's bit slice.
module serial_adder8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder8.sv
// Bit-serial adder: one full-adder slice processes one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by SERIAL_ADDER8_OVF_EN.
module serial_adder8
  import serial_adder8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER8_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER8_OVF_EN
  logic               ovf_q, ovf_d;
`endif
  logic               fa_s, fa_co;
  logic               last_bit;

  serial_adder8_fa u_slice (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER8_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Publish only the complete word so sum never shows a partial result.
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER8_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER8_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER8_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER8_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder8.sv
// Directed and swept checks for serial_adder8 (ovf checks when SERIAL_ADDER8_OVF_EN is defined).
module tb_serial_adder8;
  import serial_adder8_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADDER8_OVF_EN
  logic       ovf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  serial_adder8 #(.WIDTH(DEFAULT_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADDER8_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction; returns observed result and accept-to-valid latency.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input int stall, output logic [7:0] s, output logic c,
                        output logic o, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
    tick();
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb_v;
    cin = ~tc;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = sum;
    c = cout;
`ifdef SERIAL_ADDER8_OVF_EN
    o = ovf;
`else
    o = 1'b0;
`endif
    for (int i = 0; i < stall; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if ({cout, sum} !== 9'h000) begin tests_failed++; $display("FAIL reset_sum got %h want 000", {cout, sum}); end
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic c, o;
    int lat;
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ex [3] = '{9'h100, 9'h080, 9'h001};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 0, s, c, o, lat);
      tests_run++;
      if ({c, s} !== ex[i]) begin tests_failed++; $display("FAIL basic_sum[%0d] got %h want %h", i, {c, s}, ex[i]); end
      tests_run++;
      if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); end
`ifdef SERIAL_ADDER8_OVF_EN
      tests_run++;
      if (o !== eo[i]) begin tests_failed++; $display("FAIL basic_ovf[%0d] got %b want %b", i, o, eo[i]); end
`else
      if (o !== 1'b0 && eo[i] === 1'b1) $display("note: ovf absent");
`endif
    end
  endtask

  task automatic test_backpressure();
    int guard;
    in_valid = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin tick(); guard++; end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({out_valid, cout, sum} !== 10'h280) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got v=%b c=%b s=%h want v=1 c=0 s=80", i, out_valid, cout, sum);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_reject();
    int guard;
    in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    a = 8'hAA; b = 8'h01; cin = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL busy_in_ready[%0d] got %b want 0", guard, in_ready); end
      tick();
      guard++;
    end
    tick();
    tick();
    tests_run++;
    if ({out_valid, in_ready, cout, sum} !== 11'b10_0_01000110) begin
      tests_failed++;
      $display("FAIL busy_result got v=%b r=%b c=%b s=%h want v=1 r=0 c=0 s=46", out_valid, in_ready, cout, sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin tick(); guard++; end
    tests_run++;
    if ({cout, sum} !== 9'h0AB) begin tests_failed++; $display("FAIL busy_next got %h want 0ab", {cout, sum}); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    logic c, o;
    int lat;
    in_valid = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, busy, cout, sum} !== 12'h800) begin
      tests_failed++;
      $display("FAIL reset_mid got r=%b v=%b busy=%b c=%b s=%h want r=1 v=0 busy=0 c=0 s=00",
               in_ready, out_valid, busy, cout, sum);
    end
    run_op(8'h10, 8'h20, 1'b0, 1, s, c, o, lat);
    tests_run++;
    if ({c, s} !== 9'h030) begin tests_failed++; $display("FAIL reset_mid_next got %h want 030", {c, s}); end
  endtask

  task automatic test_sweep();
    logic [7:0] ta, tb_v, s;
    logic tc, c, o;
    int lat;
    logic [8:0] ex;
    for (int i = 0; i < 500; i++) begin
      ta   = 8'($urandom);
      tb_v = 8'($urandom);
      tc   = 1'($urandom);
      ex   = {1'b0, ta} + {1'b0, tb_v} + {8'h00, tc};
      run_op(ta, tb_v, tc, int'($urandom_range(0, 3)), s, c, o, lat);
      tests_run++;
      if ({c, s} !== ex || lat !== 8) begin
        tests_failed++;
        $display("FAIL sweep[%0d] %h+%h+%b got %h lat %0d want %h lat 8", i, ta, tb_v, tc, {c, s}, lat, ex);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
